writeback_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 21 ++
 rtl/load_formatter.sv | 41 ++++
 rtl/writeback_stage.sv | 117 +++++++++++
 tb/tb_writeback_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the writeback stage.
//   XLEN / REG_ADDR_WIDTH : datapath and register-index widths
//   F3_*                  : load funct3 encodings
//   wb_state_t            : writeback FSM states
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data aligner / extender.
//   funct3 : load type (LB/LH/LW/LBU/LHU)
//   lsb    : low two bits of the byte address
//   rdata  : word-aligned memory read data
//   data   : aligned, sign/zero-extended result
//   fault  : misaligned access or illegal funct3
module load_formatter
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      lsb,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            fault
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  // Shift the addressed lane down to bit 0.
  assign byte_sh = rdata >> {lsb, 3'b000};
  assign half_sh = rdata >> {lsb[1], 4'b0000};
  assign byte_v  = byte_sh[7:0];
  assign half_v  = half_sh[15:0];

  always_comb begin
    data  = rdata;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_v[7]}}, byte_v};
      F3_LBU: data = {24'b0, byte_v};
      F3_LH:  begin data = {{16{half_v[15]}}, half_v}; fault = lsb[0]; end
      F3_LHU: begin data = {16'b0, half_v};            fault = lsb[0]; end
      F3_LW:  fault = (lsb != 2'b00);
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: retires one instruction per handshake and drives
// the register-file write port. Loads wait for the memory response.
//   clk_i, reset_i             : clock, synchronous active-high reset
//   valid_i / ready_o          : handshake from the memory stage
//   rd_addr_i, rd_we_i         : destination register and write request
//   result_i                   : ALU / link result for non-loads
//   is_load_i, load_funct3_i,
//   addr_lsb_i                 : load descriptor
//   mem_rvalid_i, mem_rdata_i  : data-memory read response
//   rf_addr_o, rf_write_data_o,
//   rf_write_enable_o          : register-file write port (registered)
//   retire_o, load_fault_o     : one-cycle completion / fault pulses
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      rd_we_i,
  input  logic [DATA_WIDTH-1:0]     result_i,
  input  logic                      is_load_i,
  input  logic [2:0]                load_funct3_i,
  input  logic [1:0]                addr_lsb_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0]     rf_write_data_o,
  output logic                      rf_write_enable_o,
  output logic                      retire_o,
  output logic                      load_fault_o
);

  wb_state_t                 state;
  logic [REG_ADDR_WIDTH-1:0] cap_rd;
  logic                      cap_we;
  logic [2:0]                cap_funct3;
  logic [1:0]                cap_lsb;

  logic                      hs;
  logic [2:0]                fmt_funct3;
  logic [1:0]                fmt_lsb;
  logic [DATA_WIDTH-1:0]     fmt_data;
  logic                      fmt_fault;

  assign ready_o = (state == IDLE) && !reset_i;
  assign hs      = valid_i && ready_o;

  // One formatter serves both jobs: in IDLE it screens the incoming load
  // for faults, in WAIT_LOAD it formats the response with captured fields.
  assign fmt_funct3 = (state == IDLE) ? load_funct3_i : cap_funct3;
  assign fmt_lsb    = (state == IDLE) ? addr_lsb_i    : cap_lsb;

  load_formatter u_fmt (
    .funct3 (fmt_funct3),
    .lsb    (fmt_lsb),
    .rdata  (mem_rdata_i),
    .data   (fmt_data),
    .fault  (fmt_fault)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state             <= IDLE;
      cap_rd            <= '0;
      cap_we            <= 1'b0;
      cap_funct3        <= '0;
      cap_lsb           <= '0;
      rf_addr_o         <= '0;
      rf_write_data_o   <= '0;
      rf_write_enable_o <= 1'b0;
      retire_o          <= 1'b0;
      load_fault_o      <= 1'b0;
    end else begin
      rf_write_enable_o <= 1'b0;
      retire_o          <= 1'b0;
      load_fault_o      <= 1'b0;
      case (state)
        IDLE: begin
          // mem_rvalid_i in IDLE is a stray response and is dropped.
          if (hs) begin
            if (!is_load_i) begin
              rf_addr_o         <= rd_addr_i;
              rf_write_data_o   <= result_i;
              rf_write_enable_o <= rd_we_i && (rd_addr_i != '0);
              retire_o          <= 1'b1;
            end else if (fmt_fault) begin
              load_fault_o <= 1'b1;
              retire_o     <= 1'b1;
            end else begin
              cap_rd     <= rd_addr_i;
              cap_we     <= rd_we_i;
              cap_funct3 <= load_funct3_i;
              cap_lsb    <= addr_lsb_i;
              state      <= WAIT_LOAD;
            end
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid_i) begin
            rf_addr_o         <= cap_rd;
            rf_write_data_o   <= fmt_data;
            rf_write_enable_o <= cap_we && (cap_rd != '0);
            retire_o          <= 1'b1;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rd_addr_i;
  logic        rd_we_i;
  logic [31:0] result_i;
  logic        is_load_i;
  logic [2:0]  load_funct3_i;
  logic [1:0]  addr_lsb_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_write_data_o;
  logic        rf_write_enable_o;
  logic        retire_o;
  logic        load_fault_o;

  writeback_stage dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .rd_addr_i         (rd_addr_i),
    .rd_we_i           (rd_we_i),
    .result_i          (result_i),
    .is_load_i         (is_load_i),
    .load_funct3_i     (load_funct3_i),
    .addr_lsb_i        (addr_lsb_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_rdata_i       (mem_rdata_i),
    .rf_addr_o         (rf_addr_o),
    .rf_write_data_o   (rf_write_data_o),
    .rf_write_enable_o (rf_write_enable_o),
    .retire_o          (retire_o),
    .load_fault_o      (load_fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        we;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every retire pops one expectation; no retire means no pulses.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (retire_o) begin
        if (sb.size() == 0) chk("unexpected_retire", {31'b0, retire_o}, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("we", {31'b0, rf_write_enable_o}, {31'b0, e.we});
          chk("fault", {31'b0, load_fault_o}, {31'b0, e.flt});
          if (e.we) begin
            chk("addr", {27'b0, rf_addr_o}, {27'b0, e.a});
            chk("data", rf_write_data_o, e.d);
          end
        end
      end else begin
        chk("idle_we", {31'b0, rf_write_enable_o}, 32'd0);
        chk("idle_fault", {31'b0, load_fault_o}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!ready_o && t < 20) begin step(); t++; end
    if (!ready_o) chk("ready_timeout", {31'b0, ready_o}, 32'd1);
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic we, input logic [31:0] res);
    exp_t e;
    valid_i = 1'b1; is_load_i = 1'b0; rd_addr_i = rd; rd_we_i = we; result_i = res;
    wait_ready();
    e.a = rd; e.d = res; e.we = we && (rd != 0); e.flt = 1'b0;
    sb.push_back(e);
    step();
    valid_i = 1'b0;
  endtask

  // Accept a load; if legal, respond after 'dly' cycles with rdata.
  task automatic issue_load(input logic [4:0] rd, input logic we, input logic [2:0] f3,
                            input logic [1:0] lsb, input logic [31:0] rdata, input int dly,
                            input logic flt, input logic [31:0] exp_d);
    exp_t e;
    valid_i = 1'b1; is_load_i = 1'b1; rd_addr_i = rd; rd_we_i = we;
    load_funct3_i = f3; addr_lsb_i = lsb; result_i = 32'hAAAA_5555;
    wait_ready();
    if (flt) begin
      e.a = rd; e.d = 32'h0; e.we = 1'b0; e.flt = 1'b1;
      sb.push_back(e);
      step();
      valid_i = 1'b0;
    end else begin
      step();
      valid_i = 1'b0;
      for (int i = 1; i < dly; i++) begin
        chk("ready_wait", {31'b0, ready_o}, 32'd0);
        step();
      end
      chk("ready_wait", {31'b0, ready_o}, 32'd0);
      mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
      e.a = rd; e.d = exp_d; e.we = we && (rd != 0); e.flt = 1'b0;
      sb.push_back(e);
      step();
      mem_rvalid_i = 1'b0;
    end
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b1; rd_addr_i = 5'd3; rd_we_i = 1'b1;
    result_i = 32'h1111_1111; is_load_i = 1'b0; load_funct3_i = 3'b010;
    addr_lsb_i = 2'b00; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    // Reset with valid held high: nothing accepted, outputs cleared.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("rst_ready", {31'b0, ready_o}, 32'd0);
      chk("rst_we", {31'b0, rf_write_enable_o}, 32'd0);
      chk("rst_retire", {31'b0, retire_o}, 32'd0);
      chk("rst_fault", {31'b0, load_fault_o}, 32'd0);
      chk("rst_addr", {27'b0, rf_addr_o}, 32'd0);
      chk("rst_data", rf_write_data_o, 32'd0);
    end
    @(posedge clk_i); #1;
    mon_en = 1'b1;
    valid_i = 1'b0; reset_i = 1'b0;
    #1 chk("post_rst_ready", {31'b0, ready_o}, 32'd1);

    // Back-to-back ALU ops.
    issue_alu(5'd5, 1'b1, 32'h1234_5678);
    issue_alu(5'd6, 1'b1, 32'hDEAD_BEEF);
    step();

    // Load sweep.
    issue_load(5'd10, 1'b1, 3'b000, 2'd0, 32'h80F1_7F82, 3, 1'b0, 32'hFFFF_FF82);
    issue_load(5'd11, 1'b1, 3'b100, 2'd1, 32'h80F1_7F82, 3, 1'b0, 32'h0000_007F);
    issue_load(5'd12, 1'b1, 3'b001, 2'd2, 32'h80F1_7F82, 3, 1'b0, 32'hFFFF_80F1);
    issue_load(5'd13, 1'b1, 3'b101, 2'd2, 32'h80F1_7F82, 3, 1'b0, 32'h0000_80F1);
    issue_load(5'd14, 1'b1, 3'b010, 2'd0, 32'h80F1_7F82, 3, 1'b0, 32'h80F1_7F82);
    // Extra lanes: LB lsb=3 and LH lsb=0, fastest response.
    issue_load(5'd15, 1'b1, 3'b000, 2'd3, 32'h80F1_7F82, 1, 1'b0, 32'hFFFF_FF80);
    issue_load(5'd16, 1'b1, 3'b001, 2'd0, 32'h80F1_7F82, 1, 1'b0, 32'h0000_7F82);
    // Load immediately followed by an ALU op.
    issue_alu(5'd17, 1'b1, 32'hCAFE_0001);

    // Faulting loads, then a spurious response in IDLE.
    issue_load(5'd20, 1'b1, 3'b010, 2'd2, 32'h0, 0, 1'b1, 32'h0);
    issue_load(5'd21, 1'b1, 3'b001, 2'd1, 32'h0, 0, 1'b1, 32'h0);
    issue_load(5'd22, 1'b1, 3'b011, 2'd0, 32'h0, 0, 1'b1, 32'h0);
    chk("fault_ready", {31'b0, ready_o}, 32'd1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A_5A5A;
    step();
    mem_rvalid_i = 1'b0;
    step();

    // x0 write and rd_we=0 load: retire without write.
    issue_alu(5'd0, 1'b1, 32'hFFFF_FFFF);
    issue_load(5'd7, 1'b0, 3'b010, 2'd0, 32'h7777_7777, 2, 1'b0, 32'h7777_7777);

    // Reset mid-load: response afterwards must be ignored.
    valid_i = 1'b1; is_load_i = 1'b1; rd_addr_i = 5'd9; rd_we_i = 1'b1;
    load_funct3_i = 3'b010; addr_lsb_i = 2'd0;
    wait_ready();
    step();
    valid_i = 1'b0;
    reset_i = 1'b1;
    #1 chk("midrst_ready", {31'b0, ready_o}, 32'd0);
    step();
    reset_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h9999_9999;
    step();
    mem_rvalid_i = 1'b0;
    step();
    issue_alu(5'd8, 1'b1, 32'h0BAD_F00D);

    repeat (3) step();
    chk("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
